cp0: RTL and testbench
======================

# cp0

System-control coprocessor (CP0) for the pipelined MIPS core: the responder to the decode-stage control unit's `cp0_read`, `cp0_write`, `inta` and `excp_ret` signals. It holds Status, Cause and EPC, samples hardware interrupt lines into Cause, and performs exception entry and `eret` return. Entry and return raise a held redirect request toward instruction fetch. It feeds `status`/`cause` back to the control unit, which forms `inta`.

## Interface
- `HANDLER_ADDR`, default 32'h0000_0080, interrupt handler entry PC
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `int_req` input 6: hardware interrupt lines (level), map to Cause.IP[7:2]
- `cp0_read` input 1: mfc0 in MEM stage
- `rd_addr` input 5: CP0 register number for the read
- `rd_data` output 32: read data (combinational)
- `cp0_write` input 1: mtc0 in WB stage
- `wr_addr` input 5: CP0 register number for the write
- `wr_data` input 32: write data
- `inta` input 1: take-interrupt request from the control unit
- `excp_pc` input 32: PC to save in EPC when `inta` is accepted
- `excp_ret` input 1: eret decoded
- `status` output 32: Status register (reg 12)
- `cause` output 32: Cause register (reg 13)
- `epc` output 32: EPC register (reg 14)
- `redirect_valid` output 1: fetch redirect request
- `redirect_pc` output 32: redirect target
- `redirect_ack` input 1: fetch accepted the redirect

## Operation
- Status fields: IE = [0], EXL = [1], IM = [15:8]. All other bits read 0.
- Cause fields: IP = [15:8], ExcCode = [6:2]. All other bits read 0.
- Reset: status, cause, epc = 0; `redirect_valid` = 0; `redirect_pc` = 0; state RUN.
- Write masks (applied when `cp0_write`):
  - reg 12: bits [15:8], [1:0] written.
  - reg 13: only IP[1:0] (bits [9:8]) written.
  - reg 14: all 32 bits written.
  - Any other address: no effect.
- Every cycle, Cause.IP[7:2] is loaded with the registered value of `int_req`.
- Read path: `rd_data` returns the masked register value; unimplemented addresses return 0.
  - Same-cycle `cp0_write` to the same address forwards the post-mask written value.
  - Hardware IP bits are never forwarded.
  - `rd_data` is valid regardless of `cp0_read`; `cp0_read` is used for assertions only.
- State machine RUN / TAKE / RET:
  - RUN, `excp_ret`: clear EXL; `redirect_pc` ← epc (the forwarded write value if reg 14 is written that cycle); go to RET.
  - RUN, `inta` and not `excp_ret`: EPC ← `excp_pc`; EXL ← 1; ExcCode ← 0; `redirect_pc` ← HANDLER_ADDR; go to TAKE.
  - TAKE / RET: `redirect_valid` = 1 with `redirect_pc` stable. On `redirect_ack`, return to RUN.
  - TAKE / RET: `inta` and `excp_ret` are ignored.
- Simultaneous events:
  - `excp_ret` beats `inta`.
  - On entry, hardware updates of EXL, EPC and ExcCode beat a same-cycle mtc0 to those bits. Other written bits still apply.
  - mtc0 is honoured in every state.
- `inta` while EXL = 1 is a protocol error; assert it in simulation.
- Reset mid-TAKE/RET drops the redirect immediately.

## Timing
- Register writes, the IP sample, and state changes take effect on the rising edge.
- `int_req` → Cause.IP: 1 cycle.
- Cause.IP → `inta` (external combinational) → `redirect_valid`: high the cycle after `inta`.
- `redirect_valid` stays high until the cycle `redirect_ack` is sampled high, then drops the next cycle.
- Minimum redirect duration is 1 cycle (ack in the first cycle).
- `status` reflects EXL = 1 in the same cycle `redirect_valid` first rises, so `inta` cannot re-fire.
- `rd_data` is combinational from registers and the write port; no added latency.

## Structure
- Shared package:
  - register numbers (12, 13, 14)
  - Status/Cause bit positions
  - write masks
  - state encoding
  - ExcCode values
- One natural sub-module, `cp0_regfile`: Status/Cause/EPC storage, masks, and read mux with forwarding. The FSM and redirect logic live in `cp0`.

## Test plan
- Reset, then read regs 12/13/14/5 → all 0; `redirect_valid` = 0.
- mtc0 reg 12 ← 32'hFFFF_FFFF, then mfc0 reg 12 → 32'h0000_FF03. mtc0 reg 13 ← 32'hFFFF_FFFF → cause = 32'h0000_0300 (with `int_req` = 0).
- Interrupt entry:
  - Stimulus: status = 32'h0000_0401, `int_req[0]` = 1, `inta` driven from status & cause, `excp_pc` = 32'h0000_1234.
  - Response: next cycle epc = 32'h1234, EXL = 1, `redirect_pc` = 32'h80. With ack held low 3 cycles, valid is held 4 cycles total.
- eret in RUN with epc = 32'h1234 → EXL cleared; `redirect_pc` = 32'h1234; a same-cycle `inta` is ignored.
- Same-cycle mtc0 reg 14 ← 32'hDEAD_0000 with mfc0 reg 14 → `rd_data` = 32'hDEAD_0000. Same write during interrupt entry → epc = `excp_pc`.
- Assert `rst_n` low while in TAKE → `redirect_valid` drops with no clock edge; all registers read 0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, field positions, write masks, FSM encoding.
package cp0_pkg;

  localparam logic [4:0] RegStatus = 5'd12;
  localparam logic [4:0] RegCause  = 5'd13;
  localparam logic [4:0] RegEpc    = 5'd14;

  localparam int unsigned StatusIeBit  = 0;
  localparam int unsigned StatusExlBit = 1;
  localparam int unsigned CauseHwIpLsb = 10;
  localparam int unsigned CauseExcLsb  = 2;

  localparam logic [31:0] StatusWrMask = 32'h0000_FF03;
  localparam logic [31:0] CauseWrMask  = 32'h0000_0300;
  localparam logic [31:0] EpcWrMask    = 32'hFFFF_FFFF;

  localparam logic [1:0] StRun  = 2'd0;
  localparam logic [1:0] StTake = 2'd1;
  localparam logic [1:0] StRet  = 2'd2;

  localparam logic [4:0] ExcInt = 5'd0;

  function automatic logic [31:0] merge_masked(logic [31:0] old_val, logic [31:0] new_val,
                                               logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/cp0_regfile.sv
// Status/Cause/EPC storage with masked mtc0 writes, hardware updates and a forwarding read mux.
module cp0_regfile
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  int_req,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        hw_entry,
  input  logic        hw_ret,
  input  logic [31:0] excp_pc,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc,
  output logic [31:0] epc_fwd
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        wr_status, wr_cause, wr_epc, fwd;

  assign wr_status = wr_en && (wr_addr == RegStatus);
  assign wr_cause  = wr_en && (wr_addr == RegCause);
  assign wr_epc    = wr_en && (wr_addr == RegEpc);

  // Hardware updates are applied after the software write so they take priority.
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    if (wr_status) status_d = merge_masked(status_q, wr_data, StatusWrMask);
    if (wr_cause)  cause_d  = merge_masked(cause_q, wr_data, CauseWrMask);
    if (wr_epc)    epc_d    = merge_masked(epc_q, wr_data, EpcWrMask);
    cause_d[CauseHwIpLsb +: 6] = int_req;
    if (hw_entry) begin
      status_d[StatusExlBit]   = 1'b1;
      cause_d[CauseExcLsb +: 5] = ExcInt;
      epc_d                    = excp_pc;
    end
    if (hw_ret) status_d[StatusExlBit] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  assign fwd = wr_en && (wr_addr == rd_addr);

  // Forwarded Cause keeps the live hardware IP bits from the register.
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      RegStatus: rd_data = fwd ? merge_masked(status_q, wr_data, StatusWrMask) : status_q;
      RegCause:  rd_data = fwd ? merge_masked(cause_q, wr_data, CauseWrMask) : cause_q;
      RegEpc:    rd_data = fwd ? wr_data : epc_q;
      default:   rd_data = '0;
    endcase
  end

  assign status  = status_q;
  assign cause   = cause_q;
  assign epc     = epc_q;
  assign epc_fwd = wr_epc ? wr_data : epc_q;

endmodule

// File: rtl/cp0.sv
// CP0 top: exception entry / eret FSM with held fetch redirect, around the CP0 register file.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  int_req,
  input  logic        cp0_read,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  input  logic        cp0_write,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        inta,
  input  logic [31:0] excp_pc,
  input  logic        excp_ret,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ack
);

  logic [1:0]  state_q, state_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] epc_fwd;
  logic        in_run, take, ret;

  assign in_run = (state_q == StRun);
  assign ret    = in_run && excp_ret;
  assign take   = in_run && inta && !excp_ret;

  cp0_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .int_req  (int_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (cp0_write),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .hw_entry (take),
    .hw_ret   (ret),
    .excp_pc  (excp_pc),
    .status   (status),
    .cause    (cause),
    .epc      (epc),
    .epc_fwd  (epc_fwd)
  );

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      StRun: begin
        if (ret) begin
          state_d       = StRet;
          redirect_pc_d = epc_fwd;
        end else if (take) begin
          state_d       = StTake;
          redirect_pc_d = HANDLER_ADDR;
        end
      end
      StTake, StRet: if (redirect_ack) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StRun;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Driven straight from state so an async reset drops it without a clock edge.
  assign redirect_valid = (state_q == StTake) || (state_q == StRet);
  assign redirect_pc    = redirect_pc_q;

  a_inta_with_exl: assert property (@(posedge clk) disable iff (!rst_n)
    (inta && in_run && !excp_ret) |-> !status[StatusExlBit]);

  a_read_addr_known: assert property (@(posedge clk) disable iff (!rst_n)
    cp0_read |-> !$isunknown(rd_addr));

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0: register masks, forwarding, entry/eret redirects, reset.
module tb_cp0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  int_req;
  logic        cp0_read;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        cp0_write;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        inta;
  logic [31:0] excp_pc;
  logic        excp_ret;
  logic [31:0] status, cause, epc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ack;

  logic        inta_en, inta_force;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          vcnt;

  always #5 clk = ~clk;

  // Control-unit model: take interrupt when enabled, not in EXL and a masked IP is pending.
  assign inta = inta_force |
                (inta_en & status[0] & ~status[1] & (|(status[15:8] & cause[15:8])));

  cp0 #(.HANDLER_ADDR(32'h0000_0080)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .int_req        (int_req),
    .cp0_read       (cp0_read),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .cp0_write      (cp0_write),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .inta           (inta),
    .excp_pc        (excp_pc),
    .excp_ret       (excp_ret),
    .status         (status),
    .cause          (cause),
    .epc            (epc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ack   (redirect_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    rd_addr  = addr;
    cp0_read = 1'b1;
    #1;
    check(tag, rd_data, exp);
    cp0_read = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; int_req = '0; cp0_read = 1'b0; rd_addr = '0; cp0_write = 1'b0;
    wr_addr = '0; wr_data = '0; excp_pc = '0; excp_ret = 1'b0; redirect_ack = 1'b0;
    inta_en = 1'b0; inta_force = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    read_chk("rst_status", 5'd12, 32'h0);
    read_chk("rst_cause", 5'd13, 32'h0);
    read_chk("rst_epc", 5'd14, 32'h0);
    read_chk("rst_unimpl", 5'd5, 32'h0);
    check("rst_valid", 32'(redirect_valid), 32'h0);
    check("rst_rpc", redirect_pc, 32'h0);

    // Masked Status write, forwarded in the same cycle.
    cp0_write = 1'b1; wr_addr = 5'd12; wr_data = 32'hFFFF_FFFF;
    read_chk("fwd_status", 5'd12, 32'h0000_FF03);
    step();
    cp0_write = 1'b0;
    read_chk("status_mask", 5'd12, 32'h0000_FF03);

    cp0_write = 1'b1; wr_addr = 5'd13; wr_data = 32'hFFFF_FFFF;
    step();
    cp0_write = 1'b0;
    check("cause_mask", cause, 32'h0000_0300);

    cp0_write = 1'b1; wr_addr = 5'd13; wr_data = 32'h0;
    step();
    wr_addr = 5'd12; wr_data = 32'h0000_0401;
    step();
    cp0_write = 1'b0;
    check("status_401", status, 32'h0000_0401);

    // Interrupt entry.
    inta_en = 1'b1; excp_pc = 32'h0000_1234; int_req = 6'b000001;
    step();
    check("cause_ip", cause, 32'h0000_0400);
    check("inta_fire", 32'(inta), 32'h1);
    check("pre_valid", 32'(redirect_valid), 32'h0);
    step();
    inta_en = 1'b0;
    check("take_epc", epc, 32'h0000_1234);
    check("take_status", status, 32'h0000_0403);
    check("take_rpc", redirect_pc, 32'h0000_0080);
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (redirect_valid) vcnt++;
      redirect_ack = (i == 3);
      step();
    end
    redirect_ack = 1'b0;
    check("take_hold_cycles", 32'(vcnt), 32'd4);
    check("take_drop", 32'(redirect_valid), 32'h0);
    int_req = '0;

    // eret with a same-cycle inta that must be ignored.
    excp_ret = 1'b1; inta_force = 1'b1; excp_pc = 32'h0000_9999;
    step();
    excp_ret = 1'b0; inta_force = 1'b0;
    check("ret_valid", 32'(redirect_valid), 32'h1);
    check("ret_rpc", redirect_pc, 32'h0000_1234);
    check("ret_status", status, 32'h0000_0401);
    check("ret_epc_kept", epc, 32'h0000_1234);
    redirect_ack = 1'b1;
    step();
    redirect_ack = 1'b0;
    check("ret_drop", 32'(redirect_valid), 32'h0);

    // Same-cycle EPC write forwarded to the read port.
    cp0_write = 1'b1; wr_addr = 5'd14; wr_data = 32'hDEAD_0000;
    read_chk("fwd_epc", 5'd14, 32'hDEAD_0000);
    step();
    cp0_write = 1'b0;
    check("epc_written", epc, 32'hDEAD_0000);

    // EPC write racing interrupt entry: hardware wins.
    cp0_write = 1'b1; wr_addr = 5'd14; wr_data = 32'hBEEF_0000;
    excp_pc = 32'h0000_5678; inta_force = 1'b1;
    step();
    cp0_write = 1'b0; inta_force = 1'b0;
    check("race_epc", epc, 32'h0000_5678);
    check("race_valid", 32'(redirect_valid), 32'h1);

    // Asynchronous reset while in TAKE.
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(redirect_valid), 32'h0);
    check("arst_rpc", redirect_pc, 32'h0);
    check("arst_status", status, 32'h0);
    read_chk("arst_epc", 5'd14, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
